// File: rtl/pc_flow_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pc_flow_ctrl_pkg
// Brief    : Shared opcodes, state and control encodings for the PC flow sequencer.
// Revision : 1.0 - initial release
// ============================================================================
package pc_flow_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_RST     = 3'd0,
    ST_FETCH   = 3'd1,
    ST_DECODE  = 3'd2,
    ST_BRANCH  = 3'd3,
    ST_JUMP    = 3'd4,
    ST_JR      = 3'd5,
    ST_HANDOFF = 3'd6,
    ST_WAIT_EX = 3'd7
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_BLE   = 6'h06;
  localparam logic [5:0] OP_BGT   = 6'h07;
  localparam logic [5:0] FN_JR    = 6'h08;

  localparam logic [2:0] ALU_ADD    = 3'b000;
  localparam logic [2:0] ALU_SUB    = 3'b001;
  localparam logic [2:0] ALU_PASS_A = 3'b111;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  localparam logic [1:0] SRCB_B       = 2'b00;
  localparam logic [1:0] SRCB_FOUR    = 2'b01;
  localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

  localparam logic [1:0] BR_GT  = 2'b00;
  localparam logic [1:0] BR_NGT = 2'b01;
  localparam logic [1:0] BR_NE  = 2'b10;
  localparam logic [1:0] BR_EQ  = 2'b11;

  localparam logic [1:0] REGDST_RA = 2'b10;
  localparam logic [1:0] M2R_PC    = 2'b10;

  function automatic logic is_branch_op(input logic [5:0] op);
    return (op == OP_BEQ) || (op == OP_BNE) || (op == OP_BLE) || (op == OP_BGT);
  endfunction

  function automatic logic is_jump_op(input logic [5:0] op);
    return (op == OP_J) || (op == OP_JAL);
  endfunction

endpackage
`default_nettype wire

// File: rtl/pc_flow_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : pc_flow_ctrl_if
// Brief    : IR fields, execute handshake and datapath controls of the sequencer.
// Revision : 1.0 - initial release
// ============================================================================
interface pc_flow_ctrl_if;

  logic [5:0] opcode;
  logic [5:0] funct;
  logic       ex_done;

  logic       mem_read;
  logic       ir_write;
  logic       alu_src_a;
  logic [1:0] alu_src_b;
  logic [2:0] alu_op;
  logic       aluout_write;
  logic [1:0] pc_src;
  logic       pc_write;
  logic       pc_write_cond;
  logic [1:0] branch_ctrl;
  logic       ex_start;
  logic       reg_write;
  logic [1:0] reg_dst;
  logic [1:0] mem_to_reg;

  modport master (
    input  opcode, funct, ex_done,
    output mem_read, ir_write, alu_src_a, alu_src_b, alu_op, aluout_write,
           pc_src, pc_write, pc_write_cond, branch_ctrl, ex_start,
           reg_write, reg_dst, mem_to_reg
  );

  modport slave (
    output opcode, funct, ex_done,
    input  mem_read, ir_write, alu_src_a, alu_src_b, alu_op, aluout_write,
           pc_src, pc_write, pc_write_cond, branch_ctrl, ex_start,
           reg_write, reg_dst, mem_to_reg
  );

endinterface
`default_nettype wire

// File: rtl/pc_flow_branch_sel.sv
`default_nettype none
// ============================================================================
// Module   : pc_flow_branch_sel
// Brief    : Maps a latched branch opcode to the branch condition mux select.
// Revision : 1.0 - initial release
// ============================================================================
module pc_flow_branch_sel
  import pc_flow_ctrl_pkg::*;
(
  input  logic [5:0] op,
  output logic [1:0] branch_ctrl
);

  always_comb begin
    branch_ctrl = BR_GT;
    case (op)
      OP_BEQ:  branch_ctrl = BR_EQ;
      OP_BNE:  branch_ctrl = BR_NE;
      OP_BLE:  branch_ctrl = BR_NGT;
      OP_BGT:  branch_ctrl = BR_GT;
      default: branch_ctrl = BR_GT;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/pc_flow_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : pc_flow_ctrl
// Brief    : Moore fetch/decode/control-transfer sequencer with execute handoff.
//            Optional jal link write enabled by macro PC_FLOW_JAL_LINK_EN.
// Revision : 1.0 - initial release
// ============================================================================
module pc_flow_ctrl
  import pc_flow_ctrl_pkg::*;
#(
  parameter int MEM_LAT = 3,
  parameter int CNT_W   = 2
) (
  input  logic            clk,
  input  logic            reset,
  pc_flow_ctrl_if.master  bus
);

  localparam logic [CNT_W-1:0] c_cnt_last = CNT_W'(MEM_LAT - 1);

  state_t           r_state;
  state_t           w_next;
  logic [CNT_W-1:0] r_cnt;
  logic [5:0]       r_op;
  logic             w_fetch_last;
  logic [1:0]       w_bsel;

  assign w_fetch_last = (r_state == ST_FETCH) && (r_cnt == c_cnt_last);

  pc_flow_branch_sel u_branch_sel (
    .op          (r_op),
    .branch_ctrl (w_bsel)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_RST;
      r_cnt   <= '0;
      r_op    <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == ST_FETCH) begin
        r_cnt <= w_fetch_last ? '0 : r_cnt + CNT_W'(1);
      end
      // Later states decode from this copy, so IR fields may change after DECODE.
      if (r_state == ST_DECODE) begin
        r_op <= bus.opcode;
      end
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_RST:     w_next = ST_FETCH;
      ST_FETCH:   w_next = w_fetch_last ? ST_DECODE : ST_FETCH;
      ST_DECODE: begin
        if (is_branch_op(bus.opcode)) begin
          w_next = ST_BRANCH;
        end else if (is_jump_op(bus.opcode)) begin
          w_next = ST_JUMP;
        end else if ((bus.opcode == OP_RTYPE) && (bus.funct == FN_JR)) begin
          w_next = ST_JR;
        end else begin
          w_next = ST_HANDOFF;
        end
      end
      ST_BRANCH:  w_next = ST_FETCH;
      ST_JUMP:    w_next = ST_FETCH;
      ST_JR:      w_next = ST_FETCH;
      ST_HANDOFF: w_next = ST_WAIT_EX;
      ST_WAIT_EX: w_next = bus.ex_done ? ST_FETCH : ST_WAIT_EX;
      default:    w_next = ST_RST;
    endcase
  end

  always_comb begin
    bus.mem_read      = 1'b0;
    bus.ir_write      = 1'b0;
    bus.alu_src_a     = 1'b0;
    bus.alu_src_b     = SRCB_B;
    bus.alu_op        = ALU_ADD;
    bus.aluout_write  = 1'b0;
    bus.pc_src        = PCSRC_ALU;
    bus.pc_write      = 1'b0;
    bus.pc_write_cond = 1'b0;
    bus.branch_ctrl   = BR_GT;
    bus.ex_start      = 1'b0;
    bus.reg_write     = 1'b0;
    bus.reg_dst       = 2'b00;
    bus.mem_to_reg    = 2'b00;
    case (r_state)
      ST_FETCH: begin
        bus.mem_read = 1'b1;
        // PC <= PC + 4 only once the instruction word has arrived.
        if (w_fetch_last) begin
          bus.ir_write  = 1'b1;
          bus.alu_src_b = SRCB_FOUR;
          bus.pc_write  = 1'b1;
        end
      end
      ST_DECODE: begin
        bus.alu_src_b    = SRCB_IMM_SH2;
        bus.aluout_write = 1'b1;
      end
      ST_BRANCH: begin
        bus.alu_src_a     = 1'b1;
        bus.alu_op        = ALU_SUB;
        bus.pc_write_cond = 1'b1;
        bus.pc_src        = PCSRC_ALUOUT;
        bus.branch_ctrl   = w_bsel;
      end
      ST_JUMP: begin
        bus.pc_src   = PCSRC_JUMP;
        bus.pc_write = 1'b1;
`ifdef PC_FLOW_JAL_LINK_EN
        if (r_op == OP_JAL) begin
          bus.reg_write  = 1'b1;
          bus.reg_dst    = REGDST_RA;
          bus.mem_to_reg = M2R_PC;
        end
`endif
      end
      ST_JR: begin
        bus.alu_src_a = 1'b1;
        bus.alu_op    = ALU_PASS_A;
        bus.pc_write  = 1'b1;
      end
      ST_HANDOFF: bus.ex_start = 1'b1;
      default: ;
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_pc_flow_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_pc_flow_ctrl
// Brief    : Directed plus random instruction stream checked cycle by cycle.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pc_flow_ctrl;

  localparam int MEM_LAT = 3;

  typedef struct packed {
    logic       mem_read;
    logic       ir_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [2:0] alu_op;
    logic       aluout_write;
    logic [1:0] pc_src;
    logic       pc_write;
    logic       pc_write_cond;
    logic [1:0] branch_ctrl;
    logic       ex_start;
    logic       reg_write;
    logic [1:0] reg_dst;
    logic [1:0] mem_to_reg;
  } ov_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   n_assert = 0;
  int   n_fail = 0;
  ov_t  obs;

  pc_flow_ctrl_if bus ();

  pc_flow_ctrl #(.MEM_LAT(MEM_LAT), .CNT_W(2)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  always_comb obs = {bus.mem_read, bus.ir_write, bus.alu_src_a, bus.alu_src_b, bus.alu_op,
                     bus.aluout_write, bus.pc_src, bus.pc_write, bus.pc_write_cond,
                     bus.branch_ctrl, bus.ex_start, bus.reg_write, bus.reg_dst, bus.mem_to_reg};

  // Instruction class: 0 branch, 1 jump, 2 jr, 3 handed to execute FSM.
  function automatic int kind(input logic [5:0] op, input logic [5:0] fn);
    if (op >= 6'd4 && op <= 6'd7) return 0;
    if (op == 6'd2 || op == 6'd3) return 1;
    if (op == 6'd0 && fn == 6'd8) return 2;
    return 3;
  endfunction

  function automatic ov_t fetch_vec(input int i);
    ov_t v = '0;
    v.mem_read = 1'b1;
    if (i == MEM_LAT - 1) begin
      v.ir_write  = 1'b1;
      v.alu_src_b = 2'b01;
      v.pc_write  = 1'b1;
    end
    return v;
  endfunction

  function automatic ov_t decode_vec();
    ov_t v = '0;
    v.alu_src_b    = 2'b11;
    v.aluout_write = 1'b1;
    return v;
  endfunction

  function automatic ov_t exec_vec(input logic [5:0] op, input logic [5:0] fn);
    ov_t v = '0;
    case (kind(op, fn))
      0: begin
        v.alu_src_a     = 1'b1;
        v.alu_op        = 3'b001;
        v.pc_write_cond = 1'b1;
        v.pc_src        = 2'b01;
        v.branch_ctrl   = 2'(7 - int'(op));  // beq 3, bne 2, ble 1, bgt 0
      end
      1: begin
        v.pc_src   = 2'b10;
        v.pc_write = 1'b1;
`ifdef PC_FLOW_JAL_LINK_EN
        if (op == 6'h03) begin
          v.reg_write  = 1'b1;
          v.reg_dst    = 2'b10;
          v.mem_to_reg = 2'b10;
        end
`endif
      end
      2: begin
        v.alu_src_a = 1'b1;
        v.alu_op    = 3'b111;
        v.pc_write  = 1'b1;
      end
      default: v.ex_start = 1'b1;
    endcase
    return v;
  endfunction

  task automatic compare(input string tag, input ov_t exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk(input string tag, input ov_t exp, input logic [5:0] op,
                     input logic [5:0] fn, input logic exd);
    @(negedge clk);
    bus.opcode  = op;
    bus.funct   = fn;
    bus.ex_done = exd;
    #1;
    compare(tag, exp);
  endtask

  task automatic release_reset();
    @(negedge clk);
    reset = 1'b0;
    #1;
    compare("rst_cycle", '0);
  endtask

  // rst_at >= 0 asserts reset after that many WAIT_EX cycles of a handoff.
  task automatic run_instr(input string name, input logic [5:0] op, input logic [5:0] fn,
                           input int wait_n, input int rst_at);
    for (int i = 0; i < MEM_LAT; i++)
      chk($sformatf("%s_fetch%0d", name, i), fetch_vec(i), 6'($urandom), 6'($urandom),
          1'($urandom));
    chk({name, "_decode"}, decode_vec(), op, fn, 1'($urandom));
    chk({name, "_exec"}, exec_vec(op, fn), 6'($urandom), 6'($urandom), 1'($urandom));
    if (kind(op, fn) == 3) begin
      for (int w = 0; w < wait_n; w++) begin
        if (w == rst_at) begin
          @(negedge clk);
          bus.ex_done = 1'b1;
          reset = 1'b1;
          #1;
          compare({name, "_rst_async"}, '0);
          chk({name, "_rst_hold"}, '0, 6'($urandom), 6'($urandom), 1'b1);
          release_reset();
          return;
        end
        chk($sformatf("%s_wait%0d", name, w), '0, 6'($urandom), 6'($urandom), 1'b0);
      end
      chk({name, "_wait_done"}, '0, 6'($urandom), 6'($urandom), 1'b1);
    end
  endtask

  initial begin
    logic [5:0] op;
    logic [5:0] fn;
    int         sel;
    bus.opcode  = '0;
    bus.funct   = '0;
    bus.ex_done = 1'b0;
    @(negedge clk);
    #1;
    compare("reset_state", '0);
    release_reset();

    run_instr("beq",  6'h04, 6'h00, 0, -1);
    run_instr("ble",  6'h06, 6'h11, 0, -1);
    run_instr("bgt",  6'h07, 6'h08, 0, -1);
    run_instr("bne",  6'h05, 6'h3f, 0, -1);
    run_instr("jr",   6'h00, 6'h08, 0, -1);
    run_instr("j",    6'h02, 6'h08, 0, -1);
    run_instr("jal",  6'h03, 6'h00, 0, -1);
    run_instr("rtyp", 6'h00, 6'h20, 0, -1);
    run_instr("addi", 6'h08, 6'h00, 5, -1);
    run_instr("addi_rst", 6'h08, 6'h00, 5, 2);
    run_instr("after_rst_beq", 6'h04, 6'h00, 0, -1);

    for (int k = 0; k < 40; k++) begin
      sel = $urandom_range(0, 9);
      fn  = 6'($urandom);
      case (sel)
        0, 1, 2, 3: op = 6'(4 + sel);
        4:          op = 6'h02;
        5:          op = 6'h03;
        6: begin
          op = 6'h00;
          fn = 6'h08;
        end
        7:          op = 6'h00;
        default:    op = 6'($urandom);
      endcase
      run_instr($sformatf("rnd%0d_op%02h", k, op), op, fn, $urandom_range(0, 4), -1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/pc_flow_ctrl.md
Name: pc_flow_ctrl

Overview:
- Moore sequencer for the multicycle CPU's fetch, decode and control-transfer phases.
- Produces the PC-update controls consumed by the branch condition mux: pc_write, pc_write_cond, branch_ctrl, and the pc_src select.
- Hands every other instruction to the execute control FSM through a start/done handshake, then resumes fetch.

Parameters:
- MEM_LAT, 3, memory read latency in cycles for the instruction fetch; must be >= 1.
- CNT_W, 2, width of the fetch wait counter; must hold MEM_LAT-1.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- opcode  in  6  IR[31:26], valid from DECODE onward
- funct  in  6  IR[5:0]
- ex_done  in  1  execute FSM finished the handed-off instruction
- mem_read  out  1  instruction memory read strobe
- ir_write  out  1  IR load enable
- alu_src_a  out  1  0 = PC, 1 = A register
- alu_src_b  out  2  00 = B, 01 = const 4, 11 = sign-extended immediate << 2
- alu_op  out  3  000 = ADD, 001 = SUB, 111 = PASS_A
- aluout_write  out  1  ALUOut register load enable
- pc_src  out  2  00 = ALU result, 01 = ALUOut, 10 = jump target {PC[31:28], IR[25:0], 00}
- pc_write  out  1  unconditional PC write
- pc_write_cond  out  1  conditional PC write
- branch_ctrl  out  2  00 = gt, 01 = ~gt, 10 = ~eq, 11 = eq
- ex_start  out  1  one-cycle start pulse to the execute FSM
- reg_write, reg_dst[1:0], mem_to_reg[1:0]  out  link write controls; active only with the optional feature

Behaviour:
- States: RST, FETCH, DECODE, BRANCH, JUMP, JR, HANDOFF, WAIT_EX.
- Reset, asynchronous: state <= RST, counter <= 0, latched opcode <= 0.
  - Every output is 0 in RST.
  - RST -> FETCH unconditionally on the next clk.
- FETCH:
  - mem_read = 1 every cycle; the counter counts 0..MEM_LAT-1.
  - On count MEM_LAT-1: ir_write = 1, alu_src_a = 0, alu_src_b = 01, alu_op = ADD, pc_src = 00, pc_write = 1. Counter clears and the FSM goes to DECODE.
  - MEM_LAT = 1 gives a single FETCH cycle.
- DECODE:
  - alu_src_a = 0, alu_src_b = 11, alu_op = ADD, aluout_write = 1 (branch target).
  - The opcode is latched in this cycle.
  - Dispatch:
    - 0x04 / 0x05 / 0x06 / 0x07 -> BRANCH
    - 0x02 / 0x03 -> JUMP
    - opcode 0x00 with funct 0x08 -> JR
    - anything else -> HANDOFF
- BRANCH:
  - alu_src_a = 1, alu_src_b = 00, alu_op = SUB, pc_write_cond = 1, pc_src = 01.
  - branch_ctrl from the latched opcode: 0x04 beq -> 11, 0x05 bne -> 10, 0x06 ble -> 01, 0x07 bgt -> 00.
  - Next state FETCH.
- JUMP: pc_src = 10, pc_write = 1, then FETCH.
- JR: alu_src_a = 1, alu_op = PASS_A, pc_src = 00, pc_write = 1, then FETCH.
- HANDOFF: ex_start = 1 for exactly one cycle, then WAIT_EX.
- WAIT_EX:
  - All outputs 0. Stays until ex_done = 1, then FETCH.
  - ex_done is sampled only in WAIT_EX; it is ignored in every other state.
- Output invariants:
  - pc_write and pc_write_cond are never both 1.
  - branch_ctrl = 00 outside BRANCH.
  - All outputs not listed for a state are 0.
- Latency:
  - Branch, j and jr: MEM_LAT + 2 cycles from FETCH entry back to FETCH.
  - Handoff: MEM_LAT + 2 + ex wait cycles.
- Reset mid-operation (including during WAIT_EX): immediate return to RST, with no ex_start and no PC write.

Optional Feature:
- Macro: PC_FLOW_JAL_LINK_EN.
- Defined: in JUMP with latched opcode 0x03, additionally reg_write = 1, reg_dst = 10 ($31) and mem_to_reg = 10 (PC). Timing is the same single cycle.
- Undefined: jal behaves as j; reg_write, reg_dst and mem_to_reg are tied to 0.

Decomposition:
- Shared package holds the opcode/funct constants (OP_BEQ, OP_BNE, OP_BLE, OP_BGT, OP_J, OP_JAL, OP_RTYPE, FN_JR) and the encodings for state, alu_op, pc_src, alu_src_b and branch_ctrl.
- One sub-module: pc_flow_branch_sel, a combinational latched-opcode-to-branch_ctrl map. It is reused by the execute FSM checks.

Test Plan:
- Reset release, MEM_LAT = 3: RST for 1 cycle; mem_read = 1 for 3 cycles; ir_write = 1 and pc_write = 1 only on the third FETCH cycle.
- beq (0x04): BRANCH cycle shows pc_write_cond = 1, branch_ctrl = 11, pc_src = 01, alu_op = 001; pc_write = 0.
- ble (0x06) then bgt (0x07): branch_ctrl = 01, then 00 on the respective BRANCH cycles; back in FETCH on the next cycle.
- jr (op 0x00, funct 0x08): JR cycle pc_write = 1, pc_src = 00, alu_op = 111. Then j (0x02): pc_src = 10.
- addi (0x08): one ex_start pulse. Hold ex_done = 0 for 5 cycles -> FSM stays in WAIT_EX with all outputs 0. ex_done = 1 -> FETCH next cycle.
- Reset asserted in WAIT_EX -> outputs 0 immediately; fetch restarts. With PC_FLOW_JAL_LINK_EN defined, jal (0x03) -> reg_write = 1, reg_dst = 10 in the JUMP cycle.
